// File: rtl/debug_bus_pkg.sv
// Shared debug bus definitions: widths, slave addresses, regfile command layout,
// master status codes and master FSM states.
package debug_bus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;

  localparam logic [ADDR_W-1:0] REGFILE_ADDR = 8'h01;

  // Regfile debug command word: {wdata[63:32], ..., reg_idx[4:1], write[0]}
  localparam int RF_WR_BIT    = 0;
  localparam int RF_IDX_LSB   = 1;
  localparam int RF_IDX_MSB   = 4;
  localparam int RF_WDATA_LSB = 32;
  localparam int RF_WDATA_MSB = 63;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_NOACK   = 2'd1,
    ST_TIMEOUT = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ACK,
    S_WAIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/debug_bus_timer.sv
// Clearable saturating cycle counter; expired is high once the count reaches TIMEOUT-1.
// Single cycle per increment, no backpressure.
module debug_bus_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT) + 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_q, count_d;

  assign expired = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !expired) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/debug_bus_master.sv
// Single-outstanding debug bus master: one command in, one bus transaction, one response out.
// Response 4..TIMEOUT+3 cycles after the cmd handshake; cmd_ready stays low until the response is taken.
module debug_bus_master
  import debug_bus_pkg::*;
#(
  parameter int                TIMEOUT   = 16,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [1:0]        resp_status,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_start,
  inout  wire  [DATA_W-1:0] bus_data,
  input  logic              bus_accepted,
  input  logic              bus_available,
  output logic              busy
);

  state_e            state_q, state_d;
  status_e           status_q, status_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              bus_start_q, bus_start_d;
  logic              bus_drv_q, bus_drv_d;
  logic              busy_q, busy_d;
  logic              tmr_clr, tmr_inc, tmr_expired;

  debug_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  // Gated by rst so a reset landing in ISSUE frees the bus within the reset cycle.
  assign bus_data = (bus_drv_q && rst) ? wdata_q : 'z;

  assign cmd_ready   = cmd_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = rdata_q;
  assign resp_status = status_q;
  assign bus_addr    = bus_addr_q;
  assign bus_start   = bus_start_q;
  assign busy        = busy_q;

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    tmr_clr  = 1'b0;
    tmr_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_ACK;
      S_ACK: begin
        if (bus_accepted == 1'b1) begin
          tmr_clr = 1'b1;
          state_d = S_WAIT;
        end else begin
          status_d = ST_NOACK;
          rdata_d  = '0;
          state_d  = S_RESP;
        end
      end
      S_WAIT: begin
        // Availability is checked first so it wins over a same-cycle timeout.
        if (bus_available == 1'b1) begin
          rdata_d  = bus_data;
          status_d = ST_OK;
          state_d  = S_RESP;
        end else if (tmr_expired) begin
          rdata_d  = '0;
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    cmd_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    bus_start_d  = (state_d == S_ISSUE);
    bus_drv_d    = (state_d == S_ISSUE);
    busy_d       = (state_d != S_IDLE);
    bus_addr_d   = IDLE_ADDR;
    if (state_d == S_ISSUE || state_d == S_ACK || state_d == S_WAIT) begin
      bus_addr_d = addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      status_q     <= ST_OK;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      bus_addr_q   <= IDLE_ADDR;
      cmd_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      bus_start_q  <= 1'b0;
      bus_drv_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      bus_addr_q   <= bus_addr_d;
      cmd_ready_q  <= cmd_ready_d;
      resp_valid_q <= resp_valid_d;
      bus_start_q  <= bus_start_d;
      bus_drv_q    <= bus_drv_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: doc/debug_bus_master.md
# debug_bus_master

Single-outstanding transaction master for the shared debug bus. It takes commands `{addr, data}` on a valid/ready stream, typically from the host link or debug UART bridge. It issues each command as one transaction to the addressed debug slave (e.g. the register-file debug port at address 1), waits for accept and available, and returns the captured 64-bit response with a status code on a valid/ready response stream.

## Interface
Parameters:
- `TIMEOUT`, 16: max cycles spent in WAIT for `bus_available` before aborting (≥1).
- `IDLE_ADDR`, 8'h00: address driven on `bus_addr` when no transaction is active; no slave may decode it.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  master can take a command.
- `cmd_addr`  in  8  target slave address.
- `cmd_data`  in  64  payload, driven verbatim onto `bus_data`.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes response.
- `resp_data`  out  64  data captured from `bus_data`.
- `resp_status`  out  2  0 OK, 1 NOACK, 2 TIMEOUT.
- `bus_addr`  out  8  debug bus slave select.
- `bus_start`  out  1  one-cycle start strobe.
- `bus_data`  inout  64  driven only in ISSUE; `'z` otherwise.
- `bus_accepted`  in  1  slave accept. Tri-stated by unselected slaves; only logic 1 counts.
- `bus_available`  in  1  slave response valid. Only logic 1 counts.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, ACK, WAIT, RESP.
- IDLE:
  - `cmd_ready`=1, `bus_addr`=IDLE_ADDR.
  - On `cmd_valid & cmd_ready`, latch addr/data and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - `bus_addr`=latched addr, `bus_start`=1, `bus_data`=latched data.
  - Go to ACK.
- ACK (exactly 1 cycle):
  - `bus_start`=0, `bus_data` released.
  - If `bus_accepted`==1, go to WAIT and clear the timer.
  - Otherwise set status NOACK and `resp_data`=0, then go to RESP.
- WAIT:
  - If `bus_available`==1, capture `bus_data` into `resp_data`, set status OK and go to RESP.
  - Otherwise, if the timer reaches TIMEOUT-1, set status TIMEOUT and `resp_data`=0, then go to RESP.
  - Otherwise increment the timer.
  - `bus_addr` is held at the latched addr throughout WAIT.
- RESP:
  - `resp_valid`=1, `bus_addr`=IDLE_ADDR.
  - On `resp_ready`, go to IDLE.
  - `resp_data` and `resp_status` stay stable while `resp_valid` is high.
- `cmd_ready`=0 in all states but IDLE. A new command is never accepted in the same cycle a response completes.
- Available-and-timeout in the same cycle: available wins (status OK).
- `bus_available` seen in ACK is ignored. The master samples only in WAIT.

## Timing
- Reset: state IDLE, `cmd_ready`=0 during reset (1 from the first cycle after), `bus_start`=0, `bus_data`='z, `bus_addr`=IDLE_ADDR, `resp_valid`=0, `resp_data`=0, `resp_status`=0, `busy`=0, timer=0.
- Reset mid-transaction aborts immediately; the bus is released in the reset cycle. No response is produced for the aborted command.
- Cycle numbering, against the regfile slave, with cmd handshake at edge E0:
  - cycle 1: ISSUE.
  - cycle 2: ACK, `accepted`=1.
  - cycle 3: WAIT, `available`=1.
  - cycle 4: `resp_valid`=1.
- Handshake-to-response latency is therefore 4 cycles minimum and TIMEOUT+3 maximum.
- After a RESP handshake, IDLE lasts at least one cycle, so the next ISSUE is ≥2 cycles after the response handshake. This guarantees a slave with a one-cycle post-response recovery state is back in idle.
- All outputs are registered; no combinational path from `cmd_*` or `bus_*` to outputs.

## Structure
- Shared package `debug_bus_pkg`:
  - status enum (OK/NOACK/TIMEOUT, 2 bits).
  - state enum.
  - bus widths (ADDR 8, DATA 64).
  - slave address constants (REGFILE_ADDR = 1).
  - regfile command field positions: write bit 0, reg index [4:1], write data [63:32].
- Sub-module `debug_bus_timer`: clearable saturating cycle counter with `expired` flag, width $clog2(TIMEOUT)+1.

## Test plan
- Write against regfile:
  - Command: addr 1, data 64'hDEADBEEF_00000007 (write r3).
  - Expected: `bus_start` is a single pulse, `resp_valid` 4 cycles after the handshake, `resp_data`=64'h1, status 0.
- Read back:
  - Command: addr 1, data 64'h6.
  - Expected: `resp_data`=64'h00000000_DEADBEEF, status 0.
- Unmapped address:
  - Command: addr 8'h7E.
  - Expected: `bus_accepted` floats; resp status 1, data 0, 3 cycles after the handshake.
- Timeout:
  - Stub slave accepts but never raises available, TIMEOUT=4.
  - Expected: status 2 exactly 4 WAIT cycles later.
- Backpressure:
  - `resp_ready`=0 for 10 cycles while `cmd_valid` stays high.
  - Expected: `resp_*` stable, `cmd_ready`=0, and the second command is issued only after the handshake plus an IDLE cycle.
- Reset during WAIT:
  - Drive `rst`=0 for one cycle.
  - Expected: next cycle IDLE, `bus_data`='z, no `resp_valid`; the following command completes normally.
